// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: 4-bit state register plus combinational decode of all control outputs.
// Optional CTRL_ILLEGAL_TRAP_EN: an unsupported opcode parks the FSM in HALT until reset.
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       ext_op,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_ORIEX  = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t r_state;
    state_t w_next;
    logic   w_op_legal;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    assign state = r_state;

    always_comb begin
        case (opcode)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI,
            OP_ORI, OP_LW, OP_SW: w_op_legal = 1'b1;
            default:              w_op_legal = 1'b0;
        endcase
    end

    // NOTE: next state defaults to FETCH before the case, so no path leaves it unassigned (no latch);
    // the unused encodings 14-15 fall into that default as well.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_ORI:       w_next = S_ORIEX;
                    OP_J:         w_next = S_JUMP;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:      w_next = S_HALT;
`else
                    default:      w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW)      w_next = S_MEMRD;
                else if (opcode == OP_SW) w_next = S_MEMWR;
                else                      w_next = S_FETCH;
            end
            S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_ADDIEX: w_next = S_IWB;
            S_ORIEX:  w_next = S_IWB;
            S_IWB:    w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_HALT:   w_next = S_HALT;
`else
            S_HALT:   w_next = S_FETCH;
`endif
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        ext_op     = 1'b0;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                ext_op    = 1'b1;
                illegal   = !w_op_legal;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_op    = 1'b1;
            end
            S_ORIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_source = 2'b01;
                pc_write  = zero;
            end
            S_IWB:  reg_write = 1'b1;
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_HALT:  illegal = 1'b1;
            default: ;
        endcase

        // Reset must silence every side-effecting strobe even though FETCH would request a read.
        if (!rst_n) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
        end
    end

endmodule
